// File: rtl/mux_scan_pkg.sv
// Shared constants, FSM state type and channel search helper for the mux scanner.
package mux_scan_pkg;
  localparam int NUM_CH        = 4;
  localparam int SEL_W         = 2;
  localparam int CNT_W         = 4;
  localparam int DWELL_DEFAULT = 2;

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, NEXT, HOLD} state_e;

  // Lowest enabled channel >= from; returns {found, index}.
  function automatic logic [SEL_W:0] find_ch(input logic [NUM_CH-1:0] m, input int from);
    logic [SEL_W:0] r;
    r = '0;
    for (int i = NUM_CH-1; i >= 0; i--)
      if (m[i] && i >= from) r = {1'b1, SEL_W'(i)};
    return r;
  endfunction
endpackage

// File: rtl/mux_scanner_if.sv
// Handshake and mux-select bundle between the scanner and its environment.
interface mux_scanner_if;
  import mux_scan_pkg::*;
  logic              start;
  logic [NUM_CH-1:0] mask;
  logic [SEL_W-1:0]  s;
  logic              z;
  logic [NUM_CH-1:0] data;
  logic              valid;
  logic              ready;
  logic              busy;

  modport slave  (input start, mask, z, ready, output s, data, valid, busy);
  modport master (output start, mask, z, ready, input s, data, valid, busy);
endinterface

// File: rtl/scan_dwell_counter.sv
// Loadable down-counter timing the settle window of each scanned channel.
module scan_dwell_counter
  import mux_scan_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                  cnt_q <= '0;
    else if (load_i)             cnt_q <= load_val_i;
    else if (en_i && cnt_q != 0) cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == '0);
endmodule

// File: rtl/mux_scanner.sv
// Scans enabled channels of an external 4:1 mux and returns the sampled bits.
// Optional MUX_SCANNER_PARITY_EN adds a registered parity output over data.
module mux_scanner
  import mux_scan_pkg::*;
#(
  parameter int DWELL_CYCLES = DWELL_DEFAULT
)(
  input  logic         clk,
  input  logic         rst_n,
  mux_scanner_if.slave bus
`ifdef MUX_SCANNER_PARITY_EN
  , output logic       parity
`endif
);
  state_e            state_q;
  logic [SEL_W-1:0]  s_q;
  logic [NUM_CH-1:0] data_q, mask_q;
  logic              valid_q, busy_q;
`ifdef MUX_SCANNER_PARITY_EN
  logic              parity_q;
`endif

  logic [SEL_W:0]    first_d, nxt_d;
  logic [NUM_CH-1:0] data_smp_d;
  logic              accept, cnt_load, cnt_en, dwell_done;

  assign first_d    = find_ch(bus.mask, 0);
  assign nxt_d      = find_ch(mask_q, int'(s_q) + 1);
  assign accept     = (state_q == IDLE) && bus.start && first_d[SEL_W];
  // data is cleared on accept, so OR-ing the sample in is equivalent to a bit write
  assign data_smp_d = data_q | (NUM_CH'(bus.z) << s_q);

  // Loading DWELL_CYCLES-1 makes SETTLE last exactly DWELL_CYCLES cycles.
  assign cnt_load = accept || (state_q == NEXT);
  assign cnt_en   = (state_q == SETTLE);

  scan_dwell_counter u_dwell (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .en_i      (cnt_en),
    .load_val_i(CNT_W'(DWELL_CYCLES - 1)),
    .done_o    (dwell_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s_q      <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MUX_SCANNER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          mask_q   <= bus.mask;
          s_q      <= first_d[SEL_W-1:0];
          data_q   <= '0;
`ifdef MUX_SCANNER_PARITY_EN
          parity_q <= 1'b0;
`endif
          busy_q   <= 1'b1;
          state_q  <= SETTLE;
        end
        SETTLE: if (dwell_done) state_q <= SAMPLE;
        SAMPLE: begin
          data_q   <= data_smp_d;
`ifdef MUX_SCANNER_PARITY_EN
          parity_q <= ^data_smp_d;
`endif
          state_q  <= nxt_d[SEL_W] ? NEXT : HOLD;
        end
        NEXT: begin
          s_q     <= nxt_d[SEL_W-1:0];
          state_q <= SETTLE;
        end
        // valid rises one cycle after entering HOLD, giving k*(DWELL+2) latency
        HOLD: if (valid_q && bus.ready) begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          valid_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s     = s_q;
  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
`ifdef MUX_SCANNER_PARITY_EN
  assign parity    = parity_q;
`endif
endmodule

// File: tb/tb_mux_scanner.sv
// Self-checking bench: mux_scanner driving a behavioural 4:1 mux, vector table plus random scans.
module tb_mux_scanner;
  import mux_scan_pkg::*;
  localparam int DW = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  int         checks = 0;
  int         failures = 0;

  mux_scanner_if bus();
  assign bus.z = a[bus.s];

`ifdef MUX_SCANNER_PARITY_EN
  logic parity;
`endif

  mux_scanner #(.DWELL_CYCLES(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef MUX_SCANNER_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mask;
    logic [3:0] av;
    logic [3:0] exp_data;
    int         exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: ascending enabled channels encoded base-5 as (ch+1) digits.
  function automatic int model_seq(input logic [3:0] m);
    int code = 0;
    for (int i = 0; i < 4; i++) if (m[i]) code = code * 5 + i + 1;
    return code;
  endfunction

  function automatic int model_lat(input logic [3:0] m);
    return $countones(m) * (DW + 2);
  endfunction

  // Start one scan, optionally pulse start again mid-scan, wait for valid.
  task automatic run_scan(input logic [3:0] m, input logic [3:0] av, input int pulse_at,
                          output int lat, output int seq);
    logic [1:0] last;
    a = av;
    bus.mask = m;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.mask = ~m;
    chk("busy_after_start", bus.busy, 1'b1);
    last = bus.s;
    seq = int'(bus.s) + 1;
    lat = 0;
    while (bus.valid !== 1'b1 && lat < 500) begin
      bus.start = (lat == pulse_at) ? 1'b1 : 1'b0;
      if (bus.start) bus.mask = 4'hF;
      step();
      lat++;
      if (bus.s !== last) begin
        seq = seq * 5 + int'(bus.s) + 1;
        last = bus.s;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic check_scan(input string nm, input logic [3:0] m, input logic [3:0] av,
                            input int pulse_at);
    int lat, seq;
    run_scan(m, av, pulse_at, lat, seq);
    chk({nm, "_latency"}, lat, model_lat(m));
    chk({nm, "_data"}, bus.data, m & av);
    chk({nm, "_s_order"}, seq, model_seq(m));
`ifdef MUX_SCANNER_PARITY_EN
    chk({nm, "_parity"}, parity, ^(m & av));
`endif
  endtask

  task automatic handshake(input string nm, input logic [3:0] expd, input int hold);
    int bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (bus.valid !== 1'b1 || bus.data !== expd) bad++;
    end
    chk({nm, "_hold_stable"}, bad, 0);
    bus.ready = 1'b1;
    step();
    bus.ready = 1'b0;
    chk({nm, "_valid_drop"}, bus.valid, 1'b0);
    chk({nm, "_busy_drop"}, bus.busy, 1'b0);
  endtask

  initial begin
    vec_t tbl[5];
    int   bad;
    int   guard;
    logic [3:0] m, av;

    tbl[0] = '{4'hF,    4'b1010, 4'b1010, 16};
    tbl[1] = '{4'b0101, 4'b1111, 4'b0101, 8};
    tbl[2] = '{4'b1000, 4'b1000, 4'b1000, 4};
    tbl[3] = '{4'b0001, 4'b0000, 4'b0000, 4};
    tbl[4] = '{4'b0110, 4'b0101, 4'b0100, 8};

    rst_n = 1'b0; bus.start = 1'b0; bus.mask = '0; bus.ready = 1'b0; a = '0;
    repeat (3) step();
    chk("rst_s", bus.s, 2'd0);
    chk("rst_data", bus.data, 4'd0);
    chk("rst_valid", bus.valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
`ifdef MUX_SCANNER_PARITY_EN
    chk("rst_parity", parity, 1'b0);
`endif
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) begin
      int lat, seq;
      run_scan(tbl[i].mask, tbl[i].av, -1, lat, seq);
      chk($sformatf("tbl%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_data", i), bus.data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_s_order", i), seq, model_seq(tbl[i].mask));
`ifdef MUX_SCANNER_PARITY_EN
      chk($sformatf("tbl%0d_parity", i), parity, ^tbl[i].exp_data);
`endif
      handshake($sformatf("tbl%0d", i), tbl[i].exp_data, (i == 0) ? 10 : 1);
    end

    // start with empty mask is ignored
    bus.mask = 4'h0; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bad = 0;
    repeat (5) begin
      if (bus.busy !== 1'b0) bad++;
      step();
    end
    chk("zero_mask_ignored", bad, 0);

    // start pulsed mid-scan: a single result only
    check_scan("midstart", 4'b0011, 4'b0001, 3);
    handshake("midstart", 4'b0001, 0);
    bad = 0;
    repeat (20) begin
      step();
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("midstart_single_result", bad, 0);

    // reset during SETTLE of channel 2
    a = 4'b1111; bus.mask = 4'hF; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    guard = 0;
    while (bus.s !== 2'd2 && guard < 100) begin step(); guard++; end
    chk("reach_ch2", bus.s, 2'd2);
    rst_n = 1'b0;
    step();
    chk("midrst_s", bus.s, 2'd0);
    chk("midrst_data", bus.data, 4'd0);
    chk("midrst_valid", bus.valid, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    bad = 0;
    repeat (30) begin
      step();
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    chk("midrst_no_valid", bad, 0);
    check_scan("post_rst", 4'b1110, 4'b0110, -1);
    handshake("post_rst", 4'b0110, 2);

    for (int i = 0; i < 20; i++) begin
      m  = 4'($urandom_range(1, 15));
      av = 4'($urandom);
      check_scan($sformatf("rnd%0d", i), m, av, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
      handshake($sformatf("rnd%0d", i), m & av, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 Parameter: DWELL_CYCLES, default 2, settle cycles per channel before sampling (legal range 1..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 start  input  1  single-cycle request to begin one scan; sampled only in IDLE.
REQ-005 mask  input  4  channel enable, bit n = scan channel n; latched on accepted start.
REQ-006 s  output  2  select to the downstream 4:1 Mux; registered.
REQ-007 z  input  1  selected Mux output, returned for sampling.
REQ-008 data  output  4  scan result, bit n = sampled z for channel n; disabled bits 0.
REQ-009 valid  output  1  data available; held until handshake.
REQ-010 ready  input  1  consumer accepts data when valid && ready at a clock edge.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states: IDLE, SETTLE, SAMPLE, NEXT, HOLD; encoding is free.
REQ-013 IDLE: start=1 with mask!=0 latches mask, loads s with the lowest enabled channel, goes to SETTLE; start with mask==0 is ignored.
REQ-014 SETTLE: s held stable for DWELL_CYCLES cycles (dwell counter), then SAMPLE.
REQ-015 SAMPLE: one cycle; z captured into data[s]; next enabled channel above s exists -> NEXT, else -> HOLD.
REQ-016 NEXT: s loads next enabled channel (ascending, disabled channels skipped, no wrap), counter reloads, -> SETTLE.
REQ-017 Channels scanned in ascending order 0..3; each enabled channel sampled exactly once per scan.
REQ-018 data cleared to 0 on accepted start; disabled channel bits stay 0.
REQ-019 Latency: with k enabled channels, valid rises k*(DWELL_CYCLES+2) clock edges after the edge that accepted start.
REQ-020 HOLD: valid=1, data and s stable; valid && ready -> IDLE, valid=0 on following cycle.
REQ-021 ready while not in HOLD has no effect; start while busy is ignored, no queueing.
REQ-022 mask changes after start acceptance have no effect on the scan in progress.
REQ-023 s never changes during SETTLE or SAMPLE.

Reset
REQ-024 rst_n low at any clock edge, including mid-scan or during HOLD: next state IDLE; s=0, data=0, valid=0, busy=0, dwell counter=0, latched mask=0.
REQ-025 Scan aborted by reset produces no valid; no partial data survives.

Configuration
REQ-026 Macro MUX_SCANNER_PARITY_EN: when defined, output port parity (1 bit) = XOR of data, registered with data, stable while valid; reset 0.
REQ-027 Macro undefined: parity port absent, all other behaviour identical.

Structure
REQ-028 Package mux_scan_pkg holds NUM_CH=4, SEL_W=2, the FSM state typedef, and the DWELL_CYCLES default.
REQ-029 One sub-module scan_dwell_counter: loadable down-counter, load/enable inputs, done output; all else in mux_scanner.

Verification
REQ-030 Bench instantiates mux_scanner driving the existing Mux (s->s, Mux z->z) with a driven 4-bit a; bench checks against a reference model.
REQ-031 mask=4'hF, a=4'b1010, DWELL=2 -> s steps 0,1,2,3; valid at edge 16 after start; data=4'b1010; parity=0 when enabled.
REQ-032 mask=4'b0101, a=4'b1111 -> only s=0 and s=2 driven; data=4'b0101; valid at edge 8.
REQ-033 Completed scan, ready held low 10 cycles -> valid and data stable throughout; ready=1 -> valid drops next cycle, busy=0.
REQ-034 start with mask=0 -> busy stays 0; start pulsed mid-scan -> ignored, single result produced.
REQ-035 rst_n low during SETTLE of channel 2 -> next cycle s=0, data=0, valid=0, busy=0; new start scans normally.
